// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between dmem_access_unit (master) and the data SRAM (slave):
// request/grant for the address phase, rvalid for returning load data.
interface dmem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store bridge between the core and the data SRAM: lane steering, req/gnt/rvalid
// handshake with timeout. Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module dmem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               core_rd_en,
    input  logic               core_wr_en,
    input  logic [ADDR_W-1:0]  core_addr,
    input  logic [31:0]        core_wdata,
    input  logic [1:0]         core_len,
    output logic [31:0]        core_rdata,
    output logic               core_ready,
    output logic               core_err,
    output logic               core_busy,
    dmem_access_unit_if.master mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] LEN_BYTE     = 2'b00;
    localparam logic [1:0] LEN_HALF     = 2'b01;
    localparam logic [1:0] LEN_WORD     = 2'b10;
    localparam logic [1:0] LEN_RSVD     = 2'b11;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    // Natural alignment: drop the offset bits that a half/word access cannot use.
    function automatic logic [1:0] align_off(input logic [1:0] len, input logic [1:0] off);
        case (len)
            LEN_BYTE: return off;
            LEN_HALF: return {off[1], 1'b0};
            default:  return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] len, input logic [1:0] off);
        case (len)
            LEN_BYTE: begin
                case (off)
                    2'd0:    return 4'b0001;
                    2'd1:    return 4'b0010;
                    2'd2:    return 4'b0100;
                    default: return 4'b1000;
                endcase
            end
            LEN_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate_wdata(input logic [1:0] len, input logic [31:0] data);
        case (len)
            LEN_BYTE: return {4{data[7:0]}};
            LEN_HALF: return {2{data[15:0]}};
            default:  return data;
        endcase
    endfunction

    function automatic logic [31:0] extract_lane(input logic [1:0] len, input logic [1:0] off,
                                                 input logic [31:0] word);
        case (len)
            LEN_BYTE: begin
                case (off)
                    2'd0:    return {24'h000000, word[7:0]};
                    2'd1:    return {24'h000000, word[15:8]};
                    2'd2:    return {24'h000000, word[23:16]};
                    default: return {24'h000000, word[31:24]};
                endcase
            end
            LEN_HALF: return off[1] ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
            default:  return word;
        endcase
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic [7:0]        cnt_r;
    logic              is_store_r;
    logic [1:0]        len_r;
    logic [1:0]        off_r;

    logic              accept_s;
    logic              misalign_s;
    logic              reject_s;
    logic              timeout_s;
    logic [1:0]        off_s;
    logic              done_err_s;
    logic [31:0]       done_rdata_s;

    logic [31:0]       core_rdata_r;
    logic              core_ready_r;
    logic              core_err_r;
    logic              core_busy_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [3:0]        mem_be_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;

    // Decode of the incoming core request and of the timeout condition.
    always_comb begin
        accept_s = core_rd_en | core_wr_en;
        off_s    = align_off(core_len, core_addr[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign_s = ((core_len == LEN_HALF) && (core_addr[0] == 1'b1)) ||
                     ((core_len == LEN_WORD) && (core_addr[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        reject_s  = (core_len == LEN_RSVD) || misalign_s;
        timeout_s = (cnt_r == TIMEOUT_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a completing handshake wins over a same-cycle timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = reject_s ? ST_DONE : ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem.mem_gnt) begin
                    next_state_s = is_store_r ? ST_DONE : ST_WAIT;
                end else if (timeout_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rvalid || timeout_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: error flag and load result to present on entry to DONE.
    always_comb begin
        done_err_s   = 1'b0;
        done_rdata_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: done_err_s = reject_s;
            ST_REQ:  done_err_s = ~mem.mem_gnt;
            ST_WAIT: begin
                if (mem.mem_rvalid) begin
                    done_err_s   = 1'b0;
                    done_rdata_s = extract_lane(len_r, off_r, mem.mem_rdata);
                end else begin
                    done_err_s   = 1'b1;
                    done_rdata_s = 32'h0000_0000;
                end
            end
            default: begin
                done_err_s   = 1'b0;
                done_rdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Latched request attributes needed after IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_r <= 1'b0;
            len_r      <= 2'b00;
            off_r      <= 2'b00;
        end else if ((state_r == ST_IDLE) && accept_s) begin
            is_store_r <= core_wr_en;
            len_r      <= core_len;
            off_r      <= off_s;
        end
    end

    // Cycle counter for REQ+WAIT; zero while idle so it starts clean on leaving IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= 8'd0;
        end
    end

    // Registered core-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_ready_r <= 1'b0;
            core_err_r   <= 1'b0;
            core_busy_r  <= 1'b0;
            core_rdata_r <= 32'h0000_0000;
        end else begin
            core_ready_r <= (next_state_s == ST_DONE);
            core_err_r   <= (next_state_s == ST_DONE) && done_err_s;
            core_busy_r  <= (next_state_s != ST_IDLE);
            if (next_state_s == ST_DONE) begin
                core_rdata_r <= done_rdata_s;
            end
        end
    end

    // Registered memory-side outputs: loaded on IDLE->REQ, held through REQ, zero elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'b0000;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'h0000_0000;
        end else if (next_state_s == ST_REQ) begin
            mem_req_r <= 1'b1;
            if (state_r == ST_IDLE) begin
                mem_we_r    <= core_wr_en;
                mem_be_r    <= lane_be(core_len, off_s);
                mem_addr_r  <= {core_addr[ADDR_W-1:2], 2'b00};
                mem_wdata_r <= replicate_wdata(core_len, core_wdata);
            end
        end else begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'b0000;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'h0000_0000;
        end
    end

    assign core_rdata    = core_rdata_r;
    assign core_ready    = core_ready_r;
    assign core_err      = core_err_r;
    assign core_busy     = core_busy_r;
    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_be    = mem_be_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;

endmodule
